// File: rtl/handshake_arbiter.sv
// Round-robin arbiter (fixed priority with ARB_FIXED_PRIO_EN): N masters share one registered sink, at most MAX_BEATS beats per grant.
// Latency 1 cycle request->ready, 1 cycle accept->s_vaild. Stall: m_ready drops while the output word is held by !s_ready.
module handshake_arbiter #(
  parameter int NUM_MST   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 4,
  parameter int ID_W      = 2
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic [NUM_MST-1:0]        m_vaild,
  input  logic [NUM_MST*DATA_W-1:0] m_data,
  output logic [NUM_MST-1:0]        m_ready,
  output logic                      s_vaild,
  output logic [DATA_W-1:0]         s_data,
  input  logic                      s_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [7:0]        beat_cnt;
  logic              out_free;
  logic              accept;
  logic              release_grant;
  logic              sel_vld;
  logic [ID_W-1:0]   sel_idx;
  logic [DATA_W-1:0] grant_data;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (m_vaild[i]) begin
        sel_vld = 1'b1;
        sel_idx = ID_W'(i);
      end
    end
`else
    // Scan downward so the nearest requester after rr_ptr is written last.
    for (int i = NUM_MST; i >= 1; i--) begin
      if (m_vaild[(int'(rr_ptr) + i) % NUM_MST]) begin
        sel_vld = 1'b1;
        sel_idx = ID_W'((int'(rr_ptr) + i) % NUM_MST);
      end
    end
`endif
  end

  assign grant_data    = m_data[int'(grant_id) * DATA_W +: DATA_W];
  assign out_free      = !s_vaild || s_ready;
  assign accept        = (state == GRANT) && m_vaild[grant_id] && out_free;
  assign release_grant = (accept && (beat_cnt == 8'(MAX_BEATS - 1))) || !m_vaild[grant_id];
  assign busy          = (state == GRANT);

  always_comb begin
    m_ready   = '0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sel_vld) state_nxt = GRANT;
      end
      GRANT: begin
        m_ready[grant_id] = out_free;
        if (release_grant) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      s_vaild  <= 1'b0;
      s_data   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= ID_W'(NUM_MST - 1);
    end else begin
      if (state == IDLE && sel_vld) begin
        grant_id <= sel_idx;
        beat_cnt <= '0;
      end
      // A new accept refills the output register even while it drains.
      if (accept) begin
        s_vaild  <= 1'b1;
        s_data   <= grant_data;
        beat_cnt <= beat_cnt + 8'd1;
      end else if (s_ready) begin
        s_vaild  <= 1'b0;
      end
      if (state == GRANT && release_grant) rr_ptr <= grant_id;
    end
  end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Randomized + directed bench for handshake_arbiter with a transaction-level model and a downstream scoreboard.
module tb_handshake_arbiter;
  localparam int NUM_MST   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 4;
  localparam int ID_W      = 2;

  logic                      sys_clk = 1'b0;
  logic                      reset   = 1'b1;
  logic [NUM_MST-1:0]        m_vaild = '0;
  logic [NUM_MST*DATA_W-1:0] m_data  = '0;
  logic [NUM_MST-1:0]        m_ready;
  logic                      s_vaild;
  logic [DATA_W-1:0]         s_data;
  logic                      s_ready = 1'b1;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  handshake_arbiter #(
    .NUM_MST(NUM_MST), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .ID_W(ID_W)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .m_vaild(m_vaild), .m_data(m_data),
    .m_ready(m_ready), .s_vaild(s_vaild), .s_data(s_data), .s_ready(s_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] src_q [NUM_MST][$];
  logic [NUM_MST-1:0] en       = '0;
  logic [NUM_MST-1:0] pop_mask = '0;
  logic [DATA_W-1:0] exp_q [$];
  int grant_log [$];
  logic prev_busy = 1'b0;

  // Reference model: who holds the grant, how many beats it has used, what the sink holds.
  bit md_grant = 1'b0;
  int md_g     = 0;
  int md_last  = 0;
  int md_beats = 0;
  int md_rr    = NUM_MST - 1;
  bit md_sv    = 1'b0;
  int md_sd    = 0;
  bit md_free;
  bit md_acc;
  int md_pick;
  logic [NUM_MST-1:0] md_ready;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int choose(input logic [NUM_MST-1:0] req, input int rr);
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < NUM_MST; k++) if (req[k]) return k;
`else
    for (int k = 1; k <= NUM_MST; k++) if (req[(rr + k) % NUM_MST]) return (rr + k) % NUM_MST;
`endif
    return -1;
  endfunction

  always @(negedge sys_clk) begin
    check("busy", int'(busy), int'(md_grant));
    check("grant_id", int'(grant_id), md_last);
    check("s_vaild", int'(s_vaild), int'(md_sv));
    check("s_data", int'(s_data), md_sd);
    md_free  = !md_sv || s_ready;
    md_ready = '0;
    if (md_grant && md_free) md_ready[md_g] = 1'b1;
    check("m_ready", int'(m_ready), int'(md_ready));
    pop_mask = reset ? '0 : (m_vaild & m_ready);
    if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
    prev_busy = busy;
    if (reset) begin
      md_grant = 1'b0; md_g = 0; md_last = 0; md_beats = 0;
      md_rr = NUM_MST - 1; md_sv = 1'b0; md_sd = 0;
      exp_q.delete();
    end else begin
      md_acc = md_grant && m_vaild[md_g] && md_free;
      if (md_acc) begin
        exp_q.push_back(m_data[md_g*DATA_W +: DATA_W]);
        md_sd = int'(m_data[md_g*DATA_W +: DATA_W]);
        md_beats++;
      end
      md_sv = md_acc ? 1'b1 : (s_ready ? 1'b0 : md_sv);
      if (!md_grant) begin
        md_pick = choose(m_vaild, md_rr);
        if (md_pick >= 0) begin
          md_grant = 1'b1; md_g = md_pick; md_last = md_pick; md_beats = 0;
        end
      end else if (md_beats == MAX_BEATS || !m_vaild[md_g]) begin
        md_grant = 1'b0;
        md_rr    = md_g;
      end
    end
  end

  // Scoreboard monitor: every word leaving the sink must be the oldest accepted one.
  always @(negedge sys_clk) begin
    if (!reset && s_vaild && s_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_word", int'(s_data), -1);
      else                   check("sb_data", int'(s_data), int'(exp_q.pop_front()));
    end
  end

  task automatic drive();
    for (int i = 0; i < NUM_MST; i++) begin
      m_vaild[i] = en[i] && (src_q[i].size() > 0);
      m_data[i*DATA_W +: DATA_W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #2;
    for (int i = 0; i < NUM_MST; i++)
      if (pop_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic do_reset();
    en = '0;
    for (int i = 0; i < NUM_MST; i++) src_q[i].delete();
    reset = 1'b1;
    drive();
    step();
    step();
    reset = 1'b0;
    s_ready = 1'b1;
    grant_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Master 1 alone: 10..13, bubble, regrant 14,15.
    for (int k = 0; k < 6; k++) src_q[1].push_back(8'(8'h10 + k));
    en = 4'b0010;
    drive();
    for (int c = 0; c < 20; c++) step();
    check("p1_grant_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("p1_grant0", grant_log[0], 1);
      check("p1_grant1", grant_log[1], 1);
    end

    // All masters requesting: 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NUM_MST; i++)
      for (int k = 0; k < 8; k++) src_q[i].push_back(8'((i << 4) + k));
    en = '1;
    drive();
    for (int c = 0; c < 24; c++) step();
    check("p2_grant_count_ge5", int'(grant_log.size() >= 5), 1);
    if (grant_log.size() >= 5)
      for (int k = 0; k < 5; k++) check("p2_grant_order", grant_log[k], k % NUM_MST);

    // Stall on master 2's first beat A5.
    do_reset();
    for (int k = 0; k < 4; k++) src_q[2].push_back(8'(8'hA5 + k));
    en = 4'b0100;
    drive();
    begin
      int waited = 0;
      while (!s_vaild && waited < 10) begin step(); waited++; end
      check("p3_first_word_seen", int'(s_vaild), 1);
    end
    s_ready = 1'b0;
    check("p3_first_word", int'(s_data), 8'hA5);
    for (int c = 0; c < 5; c++) begin
      step();
      check("p3_stall_vaild", int'(s_vaild), 1);
      check("p3_stall_data", int'(s_data), 8'hA5);
      check("p3_stall_ready", int'(m_ready[2]), 0);
    end
    s_ready = 1'b1;
    #1;
    check("p3_resume_ready", int'(m_ready[2]), 1);
    for (int c = 0; c < 10; c++) step();

    // Master 0 drops after 2 beats, master 1 pending takes over.
    do_reset();
    for (int k = 0; k < 8; k++) src_q[0].push_back(8'(8'h30 + k));
    for (int k = 0; k < 4; k++) src_q[1].push_back(8'(8'h40 + k));
    en = 4'b0011;
    drive();
    for (int c = 0; c < 12 && src_q[0].size() > 6; c++) step();
    check("p4_two_beats", src_q[0].size(), 6);
    en[0] = 1'b0;
    drive();
    for (int c = 0; c < 10; c++) step();
    check("p4_grant_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("p4_grant0", grant_log[0], 0);
      check("p4_grant1", grant_log[1], 1);
    end

    // Reset while a word is stuck in the sink.
    do_reset();
    for (int k = 0; k < 4; k++) src_q[3].push_back(8'(8'h70 + k));
    en = 4'b1000;
    s_ready = 1'b0;
    drive();
    begin
      int waited = 0;
      while (!s_vaild && waited < 10) begin step(); waited++; end
      check("p5_word_pending", int'(s_vaild), 1);
    end
    reset = 1'b1;
    step();
    check("p5_rst_vaild", int'(s_vaild), 0);
    check("p5_rst_busy", int'(busy), 0);
    check("p5_rst_ready", int'(m_ready), 0);
    reset = 1'b0;
    s_ready = 1'b1;
    grant_log.delete();
    for (int k = 0; k < 4; k++) src_q[0].push_back(8'(8'h50 + k));
    en = 4'b1001;
    drive();
    for (int c = 0; c < 15; c++) step();
    check("p5_first_after_reset", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Masters 0 and 3 continuously requesting.
    do_reset();
    for (int k = 0; k < 12; k++) src_q[0].push_back(8'(8'h80 + k));
    for (int k = 0; k < 4; k++)  src_q[3].push_back(8'(8'hC0 + k));
    en = 4'b1001;
    drive();
    for (int c = 0; c < 30; c++) step();
`ifdef ARB_FIXED_PRIO_EN
    check("p6_first_three_m0", int'(grant_log.size() >= 3 && grant_log[0] == 0 && grant_log[1] == 0 && grant_log[2] == 0), 1);
`else
    check("p6_alternate", int'(grant_log.size() >= 2 && grant_log[0] == 0 && grant_log[1] == 3), 1);
`endif

    // Random traffic, random vaild drops, random stalls, rare resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_MST; i++) begin
        if (src_q[i].size() < 3) src_q[i].push_back(8'($urandom_range(0, 255)));
        en[i] = ($urandom_range(0, 7) != 0);
      end
      s_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      drive();
      step();
    end
    reset = 1'b0;
    en = '1;
    s_ready = 1'b1;
    drive();
    begin
      int left = 1;
      for (int c = 0; c < 400 && left != 0; c++) begin
        step();
        left = int'(s_vaild);
        for (int i = 0; i < NUM_MST; i++) left += src_q[i].size();
      end
      check("drain_done", left, 0);
    end
    check("drain_scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
